// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-issue execution controller in front of the ALU.
// Accepts one instruction per three cycles, reads operands from a small
// register file, drives registered operands to the ALU, then captures the
// ALU result and flags and writes the result back.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is high only in IDLE. in_valid is ignored
// while in_ready is low, and nothing is queued.
module alu_exec_ctrl #(
    parameter  int BW    = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic          in_use_imm,
    input  logic [BW-1:0] in_imm,
    input  logic          in_wb_en,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          res_valid,
    output logic [BW-1:0] res_data,
    output logic [AW-1:0] res_rd,
    output logic [2:0]    flags_q,
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_in_ready;
    logic [BW-1:0] r_alu_a;
    logic [BW-1:0] r_alu_b;
    logic [3:0]    r_alu_opcode;
    logic          r_res_valid;
    logic [BW-1:0] r_res_data;
    logic [AW-1:0] r_res_rd;
    logic [2:0]    r_flags;
    logic [AW-1:0] r_rd;
    logic          r_wb_en;
    logic [BW-1:0] r_regs [NREGS];

    logic [BW-1:0] w_ra_val;
    logic [BW-1:0] w_rb_val;
    logic [BW-1:0] w_opb;
    logic          w_accept;

    // Register 0 is hard-wired to zero on every read port, so its storage
    // slot never needs to be trusted.
    always_comb begin
        w_ra_val = (in_ra == '0)    ? '0 : r_regs[in_ra];
        w_rb_val = (in_rb == '0)    ? '0 : r_regs[in_rb];
        w_opb    = in_use_imm       ? in_imm : w_rb_val;
        w_accept = in_valid && r_in_ready;
        dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
    end

    // Control FSM, operand/result registers and register file writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_rd     <= '0;
            r_flags      <= '0;
            r_rd         <= '0;
            r_wb_en      <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_res_valid <= 1'b0;
                    if (w_accept) begin
                        // Operands are read here, so a register appearing as
                        // ra, rb and rd at once contributes its pre-write value.
                        r_alu_a      <= w_ra_val;
                        r_alu_b      <= w_opb;
                        r_alu_opcode <= in_opcode;
                        r_rd         <= in_rd;
                        r_wb_en      <= in_wb_en;
                        r_in_ready   <= 1'b0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU is combinational on alu_a/alu_b/alu_opcode; its
                    // result is stable by the end of this cycle.
                    r_res_data  <= alu_out;
                    r_res_rd    <= r_rd;
                    r_flags     <= alu_flags;
                    r_res_valid <= 1'b1;
                    if (r_wb_en && (r_rd != '0)) begin
                        r_regs[r_rd] <= alu_out;
                    end
                    r_state <= WB;
                end
                WB: begin
                    r_res_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_rd     = r_res_rd;
    assign flags_q    = r_flags;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl. The ALU is a stub whose result and
// flags are set by the bench for each instruction.
module tb_alu_exec_ctrl;

    localparam int BW = 16;
    localparam int AW = 3;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_EXEC = 32'd1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_ra;
    logic [AW-1:0] in_rb;
    logic          in_use_imm;
    logic [BW-1:0] in_imm;
    logic          in_wb_en;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic [3:0]    alu_opcode;
    logic [BW-1:0] alu_out;
    logic [2:0]    alu_flags;
    logic          res_valid;
    logic [BW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic [2:0]    flags_q;
    logic [AW-1:0] dbg_addr;
    logic [BW-1:0] dbg_data;
    logic [1:0]    dbg_state;

    int tests_run;
    int tests_failed;

    alu_exec_ctrl #(.BW(BW), .NREGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_wb_en   (in_wb_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .flags_q    (flags_q),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_addr = idx[AW-1:0];
        #1;
        chk(tag, {16'd0, dbg_data}, exp);
    endtask

    task automatic drive(input logic [3:0] op, input int rd, input int ra, input int rb,
                         input logic use_imm, input logic [BW-1:0] imm, input logic wb_en);
        in_opcode  = op;
        in_rd      = rd[AW-1:0];
        in_ra      = ra[AW-1:0];
        in_rb      = rb[AW-1:0];
        in_use_imm = use_imm;
        in_imm     = imm;
        in_wb_en   = wb_en;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        drive(4'h0, 0, 0, 0, 1'b0, 16'h0, 1'b0);
        alu_out      = '0;
        alu_flags    = '0;
        dbg_addr     = '0;

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_reg($sformatf("reset_r%0d", i), i, 32'h0);
        end
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_flags", {29'd0, flags_q}, 32'd0);
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_alu_a", {16'd0, alu_a}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, S_IDLE);

        // 2. r1 = 0 + imm 20
        drive(4'h0, 1, 0, 0, 1'b1, 16'd20, 1'b1);
        alu_out   = 16'd20;
        alu_flags = 3'b000;
        in_valid  = 1'b1;
        tick();                                  // cycle N+1 (EXEC)
        chk("i1_exec_alu_a", {16'd0, alu_a}, 32'd0);
        chk("i1_exec_alu_b", {16'd0, alu_b}, 32'd20);
        chk("i1_exec_in_ready", {31'd0, in_ready}, 32'd0);
        chk("i1_exec_state", {30'd0, dbg_state}, S_EXEC);
        chk("i1_exec_res_valid", {31'd0, res_valid}, 32'd0);
        // 3. second instruction offered immediately, in_valid held high
        drive(4'hA, 4, 1, 1, 1'b0, 16'h0, 1'b1);
        tick();                                  // cycle N+2 (WB)
        chk("i1_wb_res_valid", {31'd0, res_valid}, 32'd1);
        chk("i1_wb_res_data", {16'd0, res_data}, 32'd20);
        chk("i1_wb_res_rd", {29'd0, res_rd}, 32'd1);
        chk("i1_wb_in_ready", {31'd0, in_ready}, 32'd0);
        chk_reg("i1_r1", 1, 32'd20);
        alu_out = 16'd40;
        tick();                                  // cycle N+3 (IDLE, accepts here)
        chk("i2_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("i2_idle_res_valid", {31'd0, res_valid}, 32'd0);
        chk("i2_idle_alu_a_held", {16'd0, alu_a}, 32'd0);
        chk("i2_idle_alu_b_held", {16'd0, alu_b}, 32'd20);
        tick();                                  // cycle N+4 (EXEC of second)
        in_valid = 1'b0;
        chk("i2_exec_alu_a", {16'd0, alu_a}, 32'd20);
        chk("i2_exec_alu_b", {16'd0, alu_b}, 32'd20);
        chk("i2_exec_opcode", {28'd0, alu_opcode}, 32'hA);
        tick();                                  // cycle N+5 (WB)
        chk("i2_wb_res_valid", {31'd0, res_valid}, 32'd1);
        chk("i2_wb_res_data", {16'd0, res_data}, 32'd40);
        chk("i2_wb_res_rd", {29'd0, res_rd}, 32'd4);
        chk_reg("i2_r4", 4, 32'd40);
        tick();                                  // back to IDLE
        chk("i2_after_res_valid", {31'd0, res_valid}, 32'd0);

        // 4. compare: no writeback to r2, flags only
        drive(4'h2, 2, 1, 4, 1'b0, 16'h0, 1'b0);
        alu_out   = 16'hFFFF;
        alu_flags = 3'b010;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("cmp_alu_a", {16'd0, alu_a}, 32'd20);
        chk("cmp_alu_b", {16'd0, alu_b}, 32'd40);
        tick();
        chk("cmp_res_valid", {31'd0, res_valid}, 32'd1);
        chk("cmp_res_data", {16'd0, res_data}, 32'hFFFF);
        chk("cmp_flags", {29'd0, flags_q}, 32'b010);
        chk_reg("cmp_r2", 2, 32'd0);
        tick();

        // 5. write to r0 is dropped, flags still update
        drive(4'h0, 0, 0, 0, 1'b1, 16'd5, 1'b1);
        alu_out   = 16'd5;
        alu_flags = 3'b100;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("r0w_res_valid", {31'd0, res_valid}, 32'd1);
        chk("r0w_res_data", {16'd0, res_data}, 32'd5);
        chk("r0w_res_rd", {29'd0, res_rd}, 32'd0);
        chk("r0w_flags", {29'd0, flags_q}, 32'b100);
        chk_reg("r0w_r0", 0, 32'd0);
        tick();

        // 6. reset during EXEC discards the instruction
        drive(4'h0, 5, 0, 0, 1'b1, 16'd77, 1'b1);
        alu_out   = 16'd77;
        alu_flags = 3'b001;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst_pre_state", {30'd0, dbg_state}, S_EXEC);
        rst_n = 1'b0;
        tick();
        chk("rst_state", {30'd0, dbg_state}, S_IDLE);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_flags", {29'd0, flags_q}, 32'd0);
        chk_reg("rst_r5", 5, 32'd0);
        chk_reg("rst_r1", 1, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_after_res_valid", {31'd0, res_valid}, 32'd0);
        chk_reg("rst_after_r5", 5, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execution controller that sits directly upstream of the ALU and also consumes its result. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU operand and opcode inputs from registers, then captures the ALU result and flags and writes them back. It is the first sequential stage of the milestone datapath.

Parameters:
BW, 16, datapath/register width; must match the ALU BW
NREGS, 8, number of architectural registers (power of 2, >=2)
AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  controller can accept an instruction
in_opcode  input  4  ALU opcode, passed through unmodified
in_rd  input  AW  destination register
in_ra  input  AW  source register A
in_rb  input  AW  source register B
in_use_imm  input  1  1: operand B = in_imm; 0: operand B = reg[in_rb]
in_imm  input  BW  immediate operand
in_wb_en  input  1  1: write result to rd; 0: update flags only (compare)
alu_a  output  BW  registered operand A to ALU in_a
alu_b  output  BW  registered operand B to ALU in_b
alu_opcode  output  4  registered opcode to ALU
alu_out  input  BW  ALU result (combinational from alu_a/alu_b/alu_opcode)
alu_flags  input  3  ALU {overflow, negative, zero}
res_valid  output  1  one-cycle pulse: result captured
res_data  output  BW  captured result, held until next capture
res_rd  output  AW  destination of captured result
flags_q  output  3  flag register {overflow, negative, zero}
dbg_addr  input  AW  debug register read index
dbg_data  output  BW  combinational reg[dbg_addr]

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low. Sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, alu_a=0, alu_b=0, alu_opcode=0, res_valid=0, res_data=0, res_rd=0, flags_q=0, all registers 0.
- Reset mid-operation: any in-flight instruction is discarded with no writeback and no res_valid.
- Register 0 reads as 0 at all times; writes to it are dropped. flags_q still updates on such writes.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N, register the operands: alu_a<=reg[ra]; alu_b<=in_use_imm?in_imm:reg[rb]; alu_opcode<=in_opcode.
  - Also latch rd and wb_en. Go to EXEC.
- EXEC (cycle N+1):
  - in_ready=0 while in EXEC or WB.
  - The ALU evaluates combinationally.
  - At the edge ending EXEC, capture res_data<=alu_out, res_rd<=rd, flags_q<=alu_flags.
  - If wb_en and rd!=0, reg[rd]<=alu_out.
  - Go to WB.
- WB (cycle N+2):
  - res_valid=1 for exactly this cycle; the written register is visible on dbg_data.
  - Go to IDLE; in_ready=1 again from cycle N+3.
- Throughput: one instruction per 3 cycles. in_valid is ignored while in_ready=0; instructions are not queued.
- Hazards: none are possible, because a new instruction reads registers only after the prior writeback completes.
- The same register may appear as ra, rb and rd simultaneously; the pre-write value is used for all operands.
- Width: no arithmetic is performed here. Values pass through unmodified at BW bits, and opcode bit 3 passes through.
- alu_a, alu_b and alu_opcode hold their values after EXEC until the next accept.

Test Plan:
1. Reset, then check dbg_data for r0..r7: all 0; in_ready=1; flags_q=0; res_valid=0.
2. Accept {opcode=0, rd=1, ra=0, use_imm=1, imm=20, wb_en=1} with the bench ALU stub returning alu_out=20, flags=000:
   - Cycle N+1: alu_a=0, alu_b=20.
   - Cycle N+2: res_valid=1 with res_data=20, res_rd=1.
   - dbg_addr=1 reads 20.
3. Back-to-back with in_valid held high: a second instruction (ra=1, rb=1) is accepted only at cycle N+3. Its alu_a=alu_b=20, confirming the first writeback is visible.
4. Compare with wb_en=0, rd=2, stub alu_out=0xFFFF, flags=010: flags_q=010, res_valid pulses, reg2 stays 0.
5. Write to rd=0 with stub alu_out=5, flags=100: reg0 still reads 0, flags_q=100, res_data=5.
6. Assert rst_n=0 during EXEC: the next cycle shows state IDLE, in_ready=1, no res_valid, destination register unchanged (0).
